iddr_pattern_checker: RTL and testbench



---
 rtl/iddr_pattern_checker.sv | 153 +++++++++++++++
 tb/tb_iddr_pattern_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_pattern_checker.sv
// DDR receive checker: deserializes IDDR rise/fall samples MSB-first into bytes,
// bit-slips until an incrementing counter pattern is seen, then counts word errors.
module iddr_pattern_checker #(
   parameter int unsigned LOCK_COUNT   = 8,
   parameter int unsigned UNLOCK_COUNT = 4,
   parameter int unsigned ERR_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             q_rise,
   input  logic             q_fall,
   output logic [7:0]       word_out,
   output logic             word_valid,
   output logic             locked,
   output logic [2:0]       slip,
   output logic [ERR_W-1:0] error_count,
   output logic [ERR_W-1:0] word_count
);

   typedef enum logic [1:0] {StIdle, StSearch, StLocked} state_e;

   localparam logic [7:0]       LockCnt   = 8'(LOCK_COUNT);
   localparam logic [7:0]       UnlockCnt = 8'(UNLOCK_COUNT);
   localparam logic [ERR_W-1:0] CntOne    = ERR_W'(1);

   state_e           state_q, state_d;
   logic [15:0]      hist_q, hist_d;
   logic [1:0]       phase_q, phase_d;
   logic [7:0]       prev_q, prev_d;
   logic [7:0]       good_run_q, good_run_d;
   logic [7:0]       bad_run_q, bad_run_d;
   logic [7:0]       word_q, word_d;
   logic             valid_q, valid_d;
   logic [2:0]       slip_q, slip_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [ERR_W-1:0] wc_q, wc_d;

   logic [7:0] cand;
   logic [7:0] prev_inc;
   logic [7:0] good_next;
   logic [7:0] bad_next;
   logic       extract;
   logic       good;

   always_comb begin
      hist_d    = {hist_q[13:0], q_rise, q_fall};
      phase_d   = phase_q + 2'd1;
      // hist_q holds the group completed at phase 3, so phase 0 is the extraction slot
      extract   = enable && (state_q != StIdle) && (phase_q == 2'd0);
      cand      = hist_q[slip_q +: 8];
      prev_inc  = prev_q + 8'd1;
      good      = (cand == prev_inc);
      good_next = good_run_q + 8'd1;
      bad_next  = bad_run_q + 8'd1;

      state_d    = state_q;
      prev_d     = prev_q;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      word_d     = word_q;
      valid_d    = 1'b0;
      slip_d     = slip_q;
      err_d      = err_q;
      wc_d       = wc_q;

      if (extract) begin
         word_d  = cand;
         valid_d = 1'b1;
         prev_d  = cand;
      end

      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d    = StSearch;
               err_d      = '0;
               wc_d       = '0;
               good_run_d = '0;
               bad_run_d  = '0;
            end
            StSearch: begin
               if (extract) begin
                  if (good) begin
                     good_run_d = good_next;
                     if (good_next == LockCnt) begin
                        state_d   = StLocked;
                        bad_run_d = '0;
                     end
                  end else begin
                     good_run_d = '0;
                     slip_d     = slip_q + 3'd1;
                  end
               end
            end
            StLocked: begin
               if (extract) begin
                  if (wc_q != '1) wc_d = wc_q + CntOne;
                  if (good) begin
                     bad_run_d = '0;
                  end else begin
                     if (err_q != '1) err_d = err_q + CntOne;
                     bad_run_d = bad_next;
                     if (bad_next == UnlockCnt) begin
                        state_d    = StSearch;
                        good_run_d = '0;
                     end
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         hist_q     <= '0;
         phase_q    <= '0;
         prev_q     <= '0;
         good_run_q <= '0;
         bad_run_q  <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         slip_q     <= '0;
         err_q      <= '0;
         wc_q       <= '0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         phase_q    <= phase_d;
         prev_q     <= prev_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         slip_q     <= slip_d;
         err_q      <= err_d;
         wc_q       <= wc_d;
      end
   end

   assign word_out    = word_q;
   assign word_valid  = valid_q;
   assign locked      = (state_q == StLocked);
   assign slip        = slip_q;
   assign error_count = err_q;
   assign word_count  = wc_q;

endmodule

// File: tb/tb_iddr_pattern_checker.sv
// Directed bench for iddr_pattern_checker: a default instance plus an ERR_W=4 instance
// on the same stimulus, fed in 4-cycle groups aligned to the checker's word phase.
module tb_iddr_pattern_checker;

   logic clk;
   logic rst;
   logic enable;
   logic q_rise;
   logic q_fall;

   logic [7:0]  word_out;
   logic        word_valid;
   logic        locked;
   logic [2:0]  slip;
   logic [15:0] error_count;
   logic [15:0] word_count;

   logic [7:0]  word_out4;
   logic        word_valid4;
   logic        locked4;
   logic [2:0]  slip4;
   logic [3:0]  error_count4;
   logic [3:0]  word_count4;

   int n_checks = 0;
   int n_errors = 0;

   // values seen one cycle into a group, i.e. the result of extracting the previous group
   logic [7:0]  c_word;
   logic        c_valid;
   logic        c_locked;
   logic [2:0]  c_slip;
   logic [15:0] c_err;
   logic [15:0] c_wc;
   logic [3:0]  c4_err;
   logic [3:0]  c4_wc;
   logic        c4_locked;

   iddr_pattern_checker dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .q_rise      (q_rise),
      .q_fall      (q_fall),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .locked      (locked),
      .slip        (slip),
      .error_count (error_count),
      .word_count  (word_count)
   );

   iddr_pattern_checker #(.ERR_W(4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .q_rise      (q_rise),
      .q_fall      (q_fall),
      .word_out    (word_out4),
      .word_valid  (word_valid4),
      .locked      (locked4),
      .slip        (slip4),
      .error_count (error_count4),
      .word_count  (word_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one byte as four rise/fall pairs, MSB first; called on a negedge.
   task automatic grp(input logic [7:0] b);
      logic [7:0] s;
      s = b;
      for (int i = 0; i < 4; i++) begin
         q_rise = s[7];
         q_fall = s[6];
         s      = s << 2;
         @(negedge clk);
         if (i == 0) begin
            c_word    = word_out;
            c_valid   = word_valid;
            c_locked  = locked;
            c_slip    = slip;
            c_err     = error_count;
            c_wc      = word_count;
            c4_err    = error_count4;
            c4_wc     = word_count4;
            c4_locked = locked4;
         end
      end
   endtask

   initial begin
      logic [7:0] pw;
      logic [7:0] w;

      rst    = 1'b0;
      enable = 1'b0;
      q_rise = 1'b0;
      q_fall = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_word",  {24'd0, word_out}, 32'h0);
      chk("rst_valid", {31'd0, word_valid}, 32'h0);
      chk("rst_locked", {31'd0, locked}, 32'h0);
      chk("rst_slip",  {29'd0, slip}, 32'h0);
      chk("rst_err",   {16'd0, error_count}, 32'h0);
      chk("rst_wc",    {16'd0, word_count}, 32'h0);

      // Aligned counter 01,02,... ; first word meets prev=0 after reset
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b1;
      grp(8'h01);
      chk("idle_no_word", {31'd0, c_valid}, 32'h0);
      for (int k = 2; k <= 8; k++) grp(8'(k));
      chk("prelock_locked", {31'd0, c_locked}, 32'h0);
      chk("prelock_word", {24'd0, c_word}, 32'h07);
      grp(8'h09);
      chk("lock_locked", {31'd0, c_locked}, 32'h1);
      chk("lock_valid", {31'd0, c_valid}, 32'h1);
      chk("lock_word", {24'd0, c_word}, 32'h08);
      chk("lock_slip", {29'd0, c_slip}, 32'h0);
      chk("lock_wc", {16'd0, c_wc}, 32'h0);
      chk("valid_pulse", {31'd0, word_valid}, 32'h0);
      grp(8'h0A);
      chk("wc_1", {16'd0, c_wc}, 32'h1);
      chk("word_9", {24'd0, c_word}, 32'h09);
      grp(8'h0B);
      chk("wc_2", {16'd0, c_wc}, 32'h2);
      chk("err_0", {16'd0, c_err}, 32'h0);
      for (int k = 12; k <= 8'h3F; k++) grp(8'(k));

      // 0x40 with bit 4 flipped, then clean 41,42,43
      grp(8'h50);
      chk("pre_flip_word", {24'd0, c_word}, 32'h3F);
      chk("pre_flip_wc", {16'd0, c_wc}, 32'd55);
      grp(8'h41);
      chk("flip_err", {16'd0, c_err}, 32'h1);
      chk("flip_locked", {31'd0, c_locked}, 32'h1);
      grp(8'h42);
      chk("flip_next_err", {16'd0, c_err}, 32'h2);
      grp(8'h43);
      chk("flip_recover_err", {16'd0, c_err}, 32'h2);
      chk("flip_recover_wc", {16'd0, c_wc}, 32'd58);
      chk("flip_recover_word", {24'd0, c_word}, 32'h42);

      // Four consecutive bad words drop lock
      grp(8'h44);
      grp(8'h45);
      grp(8'hAA);
      grp(8'hAA);
      chk("bad1_err", {16'd0, c_err}, 32'd3);
      chk("bad1_locked", {31'd0, c_locked}, 32'h1);
      grp(8'hAA);
      grp(8'hAA);
      chk("bad3_locked", {31'd0, c_locked}, 32'h1);
      grp(8'hAB);
      chk("bad4_err", {16'd0, c_err}, 32'd6);
      chk("bad4_locked", {31'd0, c_locked}, 32'h0);
      chk("bad4_slip", {29'd0, c_slip}, 32'h0);
      chk("bad4_wc", {16'd0, c_wc}, 32'd65);
      for (int v = 8'hAC; v <= 8'hB2; v++) grp(8'(v));
      chk("relock_pending", {31'd0, c_locked}, 32'h0);
      grp(8'hB3);
      chk("relock_locked", {31'd0, c_locked}, 32'h1);
      chk("relock_slip", {29'd0, c_slip}, 32'h0);
      chk("relock_wc", {16'd0, c_wc}, 32'd65);
      chk("sat4_wc", {28'd0, c4_wc}, 32'hF);

      // Alternate bad/good: one error per pair, lock held
      for (int p = 0; p < 16; p++) begin
         grp(8'h00);
         grp(8'h01);
      end
      grp(8'h02);
      chk("alt_err", {16'd0, c_err}, 32'd22);
      chk("alt_wc", {16'd0, c_wc}, 32'd98);
      chk("alt_locked", {31'd0, c_locked}, 32'h1);
      chk("sat4_err", {28'd0, c4_err}, 32'hF);
      chk("sat4_locked", {31'd0, c4_locked}, 32'h1);

      enable = 1'b0;
      grp(8'h00);
      chk("dis_valid", {31'd0, c_valid}, 32'h0);
      chk("dis_locked", {31'd0, c_locked}, 32'h0);
      chk("dis_err_hold", {16'd0, c_err}, 32'd22);
      chk("dis_wc_hold", {16'd0, c_wc}, 32'd98);

      // Re-enable with word boundaries 3 bits before group boundaries; words FF,00,01,...
      enable = 1'b1;
      grp(8'h07);
      chk("en_err_clr", {16'd0, c_err}, 32'h0);
      chk("en_wc_clr", {16'd0, c_wc}, 32'h0);
      chk("en4_err_clr", {28'd0, c4_err}, 32'h0);
      chk("en_valid", {31'd0, c_valid}, 32'h0);
      pw = 8'hFF;
      for (int j = 1; j <= 22; j++) begin
         w = (j == 16) ? 8'hEE : 8'(j - 1);
         grp({pw[4:0], w[7:5]});
         pw = w;
         if (j == 1) begin
            chk("s_e1_word", {24'd0, c_word}, 32'h07);
            chk("s_e1_slip", {29'd0, c_slip}, 32'h1);
         end
         if (j == 2) begin
            chk("s_e2_word", {24'd0, c_word}, 32'hFC);
            chk("s_e2_slip", {29'd0, c_slip}, 32'h2);
         end
         if (j == 3) begin
            chk("s_e3_word", {24'd0, c_word}, 32'h00);
            chk("s_e3_slip", {29'd0, c_slip}, 32'h3);
         end
         if (j == 4) begin
            chk("s_e4_word", {24'd0, c_word}, 32'h01);
            chk("s_e4_slip", {29'd0, c_slip}, 32'h3);
         end
         if (j == 10) chk("s_e10_locked", {31'd0, c_locked}, 32'h0);
         if (j == 11) begin
            chk("s_lock_locked", {31'd0, c_locked}, 32'h1);
            chk("s_lock_word", {24'd0, c_word}, 32'h08);
            chk("s_lock_slip", {29'd0, c_slip}, 32'h3);
            chk("s4_lock_locked", {31'd0, c4_locked}, 32'h1);
         end
         if (j == 18) begin
            chk("s_bad_word", {24'd0, c_word}, 32'hEE);
            chk("s_bad_err", {16'd0, c_err}, 32'h1);
         end
         if (j == 20) begin
            chk("s_rec_err", {16'd0, c_err}, 32'h2);
            chk("s_rec_wc", {16'd0, c_wc}, 32'd9);
            chk("s_rec_word", {24'd0, c_word}, 32'h11);
         end
      end

      // Asynchronous reset while locked with errors recorded
      #2 rst = 1'b1;
      #1;
      chk("arst_word", {24'd0, word_out}, 32'h0);
      chk("arst_locked", {31'd0, locked}, 32'h0);
      chk("arst_slip", {29'd0, slip}, 32'h0);
      chk("arst_err", {16'd0, error_count}, 32'h0);
      chk("arst_wc", {16'd0, word_count}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) grp(8'(k));
      grp(8'h09);
      chk("post_rst_locked", {31'd0, c_locked}, 32'h1);
      chk("post_rst_slip", {29'd0, c_slip}, 32'h0);
      chk("post_rst_word", {24'd0, c_word}, 32'h08);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
